req_issuer: RTL

- Upstream requester for the level-handshake responder stage that consumes req_valid and returns req_ready.
- Buffers commands in a small FIFO and issues each one as a four-phase handshake on req_valid/req_ready, carrying a payload on req_data.
- Drops a request if the responder does not answer in time, and keeps completion and error status for software/test observation.

---
 rtl/req_issuer_pkg.sv | 20 ++
 rtl/req_cmd_fifo.sv | 49 ++++
 rtl/req_issuer.sv | 123 ++++++++++++
 3 files changed

// File: rtl/req_issuer_pkg.sv
// Shared types and helpers for the request issuer: FSM state encoding and pointer-width math.
package req_issuer_pkg;

    // One-hot encoding so a corrupted state is easy to detect and recover from.
    typedef enum logic [2:0] {
        IDLE    = 3'b001,
        ASSERT  = 3'b010,
        RELEASE = 3'b100
    } state_t;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) result = i + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/req_cmd_fifo.sv
// Synchronous command FIFO; head visible combinationally, a push is seen one cycle later.
// Pushes are ignored while full and pops while empty; o_full is the only backpressure.
module req_cmd_fifo
    import req_issuer_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_push,
    input  logic              i_pop,
    input  logic [DATA_W-1:0] i_din,
    output logic [DATA_W-1:0] o_dout,
    output logic              o_full,
    output logic              o_empty
);

    localparam int AW = clog2(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW:0]       r_wr_ptr;
    logic [AW:0]       r_rd_ptr;
    logic              w_do_push;
    logic              w_do_pop;

    // Extra MSB distinguishes full from empty when the index bits match.
    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_dout    = r_mem[r_rd_ptr[AW-1:0]];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_din;
    end

endmodule

// File: rtl/req_issuer.sv
// Buffers commands and issues each as a four-phase req_valid/req_ready handshake; 4 cycles/request
// with a 1-cycle responder. Commands back up into the FIFO; o_cmd_ready drops only when it is full.
module req_issuer
    import req_issuer_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_cmd_valid,
    output logic              o_cmd_ready,
    input  logic [DATA_W-1:0] i_cmd_data,
    output logic              o_req_valid,
    input  logic              i_req_ready,
    output logic [DATA_W-1:0] o_req_data,
    output logic              o_busy,
    output logic [CNT_W-1:0]  o_done_count,
    output logic              o_timeout_err
);

    localparam int TCNT_W = (clog2(TIMEOUT + 1) < 1) ? 1 : clog2(TIMEOUT + 1);
    localparam logic [TCNT_W-1:0] TLAST = TCNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_t              r_state;
    logic                r_req_valid;
    logic [DATA_W-1:0]   r_req_data;
    logic [TCNT_W-1:0]   r_tcnt;
    logic [CNT_W-1:0]    r_done_count;
    logic                r_timeout_err;
    logic                r_acked;

    logic                w_push;
    logic                w_pop;
    logic                w_full;
    logic                w_empty;
    logic                w_timeout;
    logic [DATA_W-1:0]   w_head;

    assign w_push    = i_cmd_valid && !w_full;
    // The head leaves the FIFO exactly when the FSM moves into ASSERT.
    assign w_pop     = !w_empty && ((r_state == IDLE) || ((r_state == RELEASE) && !i_req_ready));
    assign w_timeout = (TIMEOUT != 0) && (r_tcnt == TLAST);

    req_cmd_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_din   (i_cmd_data),
        .o_dout  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= IDLE;
            r_req_valid   <= 1'b0;
            r_req_data    <= '0;
            r_tcnt        <= '0;
            r_done_count  <= '0;
            r_timeout_err <= 1'b0;
            r_acked       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_req_valid <= 1'b0;
                    if (w_pop) begin
                        r_req_valid <= 1'b1;
                        r_req_data  <= w_head;
                        r_tcnt      <= '0;
                        r_state     <= ASSERT;
                    end
                end
                ASSERT: begin
                    if (i_req_ready) begin
                        r_req_valid <= 1'b0;
                        r_acked     <= 1'b1;
                        r_state     <= RELEASE;
                    end else if (w_timeout) begin
                        r_req_valid   <= 1'b0;
                        r_timeout_err <= 1'b1;
                        r_acked       <= 1'b0;
                        r_state       <= RELEASE;
                    end else begin
                        r_tcnt <= r_tcnt + 1'b1;
                    end
                end
                RELEASE: begin
                    if (!i_req_ready) begin
                        if (r_acked) r_done_count <= r_done_count + 1'b1;
                        if (w_pop) begin
                            r_req_valid <= 1'b1;
                            r_req_data  <= w_head;
                            r_tcnt      <= '0;
                            r_state     <= ASSERT;
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_req_valid <= 1'b0;
                end
            endcase
        end
    end

    assign o_cmd_ready   = !w_full;
    assign o_req_valid   = r_req_valid;
    assign o_req_data    = r_req_data;
    assign o_busy        = (r_state != IDLE) || !w_empty;
    assign o_done_count  = r_done_count;
    assign o_timeout_err = r_timeout_err;

endmodule
